// File: rtl/rof_window_reader_pkg.sv
// rtl/rof_window_reader_pkg.sv - shared states, parameter field offsets and sizing for the window reader
package rof_window_reader_pkg;

  localparam int DEF_MAX_N = 5;

  localparam int N_LSB      = 0;
  localparam int N_MSB      = 7;
  localparam int K_LSB      = 8;
  localparam int K_MSB      = 15;
  localparam int STRIDE_LSB = 16;
  localparam int STRIDE_MSB = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_READ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_e;

  // Row/col counters must be able to reach N (one past the last row).
  function automatic int cnt_width(input int max_n);
    return $clog2(max_n + 1);
  endfunction

endpackage

// File: rtl/rof_mask_scanner.sv
// rtl/rof_mask_scanner.sv - row-major window position scanner with mask select and last-enabled lookahead
module rof_mask_scanner
  import rof_window_reader_pkg::*;
#(
  parameter int MAX_N = DEF_MAX_N,
  localparam int CW = cnt_width(MAX_N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_advance,
  input  logic [7:0]             i_n,
  input  logic [MAX_N*MAX_N-1:0] i_mask,
  output logic [CW-1:0]          o_row,
  output logic [CW-1:0]          o_col,
  output logic                   o_en,
  output logic                   o_past,
  output logic                   o_last
);

  logic [CW-1:0]          r_row;
  logic [CW-1:0]          r_col;
  logic [MAX_N*MAX_N-1:0] w_eff;
  logic                   w_en;
  logic                   w_later;
  int                     w_cur;

  // w_eff is indexed by linear position r*MAX_N+c, already clipped to the N x N window.
  always_comb begin
    w_eff   = '0;
    w_en    = 1'b0;
    w_later = 1'b0;
    w_cur   = int'(r_row) * MAX_N + int'(r_col);
    for (int r = 0; r < MAX_N; r++) begin
      for (int c = 0; c < MAX_N; c++) begin
        w_eff[r*MAX_N+c] = i_mask[MAX_N*MAX_N-1-(r*MAX_N+c)] && (r < int'(i_n)) && (c < int'(i_n));
      end
    end
    for (int p = 0; p < MAX_N*MAX_N; p++) begin
      if (p == w_cur) w_en = w_eff[p];
      if (p > w_cur && w_eff[p]) w_later = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (8'(r_col) == i_n - 8'd1) begin
        r_col <= '0;
        r_row <= r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_past = (8'(r_row) >= i_n);
  assign o_en   = w_en & ~o_past;
  assign o_last = ~w_later;

endmodule

// File: rtl/rof_window_reader.sv
// rtl/rof_window_reader.sv - fetches the enabled pixels of an N x N window one byte read at a time
module rof_window_reader
  import rof_window_reader_pkg::*;
#(
  parameter int MAX_N = DEF_MAX_N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [31:0]            i_base_addr,
  input  logic [31:0]            i_parameters,
  input  logic [MAX_N*MAX_N-1:0] i_mask,
  output logic                   o_rd_en,
  output logic [31:0]            o_rd_addr,
  input  logic [7:0]             i_rd_data,
  output logic [7:0]             o_px,
  output logic                   o_px_valid,
  output logic                   o_px_last,
  input  logic                   i_px_ready,
  output logic [7:0]             o_rank,
  output logic [4:0]             o_count,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int CW = cnt_width(MAX_N);

  state_e                 r_state, w_next;
  logic [31:0]            r_base, r_addr;
  logic [7:0]             r_n, r_rank, r_px;
  logic [15:0]            r_stride;
  logic [MAX_N*MAX_N-1:0] r_mask;
  logic                   r_px_last, r_err;
  logic [4:0]             r_count;

  logic                   w_load, w_adv, w_ld_addr, w_cap, w_take, w_bad;
  logic [7:0]             w_in_n;
  logic [CW-1:0]          w_row, w_col;
  logic                   w_en, w_past, w_last;
  logic [31:0]            w_addr;

  assign w_in_n = i_parameters[N_MSB:N_LSB];
  assign w_bad  = (w_in_n == 8'd0) || (w_in_n > 8'(MAX_N));
  assign w_addr = r_base + 32'(r_stride) * 32'(w_row) + 32'(w_col);

  rof_mask_scanner #(.MAX_N(MAX_N)) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_load),
    .i_advance (w_adv),
    .i_n       (r_n),
    .i_mask    (r_mask),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_en      (w_en),
    .o_past    (w_past),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    w_ld_addr = 1'b0;
    w_cap     = 1'b0;
    w_take    = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_load = 1'b1;
        w_next = w_bad ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        if (w_past) begin
          w_next = S_DONE;
        end else if (w_en) begin
          w_ld_addr = 1'b1;
          w_next    = S_READ;
        end else begin
          w_adv = 1'b1;
        end
      end
      S_READ: w_next = S_WAIT;
      S_WAIT: begin
        w_cap  = 1'b1;
        w_next = S_HOLD;
      end
      S_HOLD: if (i_px_ready) begin
        w_take = 1'b1;
        if (r_px_last) begin
          w_next = S_DONE;
        end else begin
          w_adv  = 1'b1;
          w_next = S_SCAN;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base    <= '0;
      r_n       <= '0;
      r_rank    <= '0;
      r_stride  <= '0;
      r_mask    <= '0;
      r_addr    <= '0;
      r_px      <= '0;
      r_px_last <= 1'b0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      // A rejected start goes straight to DONE, so r_err lines up with the o_done pulse.
      r_err <= w_load & w_bad;
      if (w_load) begin
        r_base   <= i_base_addr;
        r_n      <= w_in_n;
        r_rank   <= i_parameters[K_MSB:K_LSB];
        r_stride <= i_parameters[STRIDE_MSB:STRIDE_LSB];
        r_mask   <= i_mask;
        r_count  <= '0;
      end
      if (w_ld_addr) r_addr <= w_addr;
      if (w_cap) begin
        r_px      <= i_rd_data;
        r_px_last <= w_last;
      end
      if (w_take) begin
        r_count   <= r_count + 5'd1;
        r_px_last <= 1'b0;
      end
    end
  end

  assign o_rd_en    = (r_state == S_READ);
  assign o_rd_addr  = r_addr;
  assign o_px       = r_px;
  assign o_px_valid = (r_state == S_HOLD);
  assign o_px_last  = r_px_last;
  assign o_rank     = r_rank;
  assign o_count    = r_count;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_err      = r_err;

endmodule

// File: tb/tb_rof_window_reader.sv
// tb/tb_rof_window_reader.sv - self-checking bench for rof_window_reader against a window/mask reference model
module tb_rof_window_reader;

  localparam int MN = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [31:0]       i_base_addr;
  logic [31:0]       i_parameters;
  logic [MN*MN-1:0]  i_mask;
  logic              o_rd_en;
  logic [31:0]       o_rd_addr;
  logic [7:0]        i_rd_data = 8'hEE;
  logic [7:0]        o_px;
  logic              o_px_valid;
  logic              o_px_last;
  logic              i_px_ready;
  logic [7:0]        o_rank;
  logic [4:0]        o_count;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q[$];
  logic [7:0]  px_q[$];
  bit          last_q[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  bit          rd_pend = 1'b0;
  logic [31:0] rd_paddr = '0;

  rof_window_reader #(.MAX_N(MN)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_parameters (i_parameters),
    .i_mask       (i_mask),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_px         (o_px),
    .o_px_valid   (o_px_valid),
    .o_px_last    (o_px_last),
    .i_px_ready   (i_px_ready),
    .o_rank       (o_rank),
    .o_count      (o_count),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem8(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  // Memory returns data only in the cycle after the request; otherwise a marker value.
  always @(negedge clk) begin
    if (o_rd_en) rd_q.push_back(o_rd_addr);
    i_rd_data = rd_pend ? mem8(rd_paddr) : 8'hEE;
    rd_pend   = o_rd_en;
    rd_paddr  = o_rd_addr;
    if (o_px_valid && i_px_ready) begin
      px_q.push_back(o_px);
      last_q.push_back(o_px_last);
    end
    if (o_done) done_cnt++;
    if (o_err)  err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_q.delete();
    px_q.delete();
    last_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({o_rd_en, o_rd_addr, o_px, o_px_valid, o_px_last, o_rank, o_count, o_busy, o_done, o_err});
  endfunction

  // mode: 0 ready high, 1 random ready, 2 ready held low 5 cycles on the 2nd pixel
  task automatic run_fetch(input string tag, input logic [31:0] base, input logic [7:0] n,
                           input logic [7:0] k, input logic [15:0] stride,
                           input logic [MN*MN-1:0] mask, input int mode, input bit poke);
    logic [31:0] exp_q[$];
    int          cyc;
    int          stall;
    int          lim;
    logic [7:0]  held;
    bit          bad;
    clear_log();
    bad = (n == 8'd0) || (n > 8'(MN));
    if (!bad) begin
      for (int r = 0; r < int'(n); r++)
        for (int c = 0; c < int'(n); c++)
          if (mask[MN*MN-1-(r*MN+c)]) exp_q.push_back(base + 32'(r) * 32'(stride) + 32'(c));
    end
    @(posedge clk); #1;
    i_base_addr  = base;
    i_parameters = {stride, k, n};
    i_mask       = mask;
    i_px_ready   = 1'b1;
    i_start      = 1'b1;
    @(posedge clk); #1;
    i_start      = 1'b0;
    i_base_addr  = $urandom;
    i_parameters = $urandom;
    i_mask       = MN*MN'($urandom);
    cyc = 0;
    stall = 0;
    held = '0;
    while (done_cnt == 0 && cyc < 1000) begin
      cyc++;
      i_start = poke && (cyc == 4);
      if (mode == 1) begin
        i_px_ready = 1'($urandom_range(0, 1));
      end else if (mode == 2 && o_px_valid && px_q.size() == 1 && stall < 5) begin
        i_px_ready = 1'b0;
        if (stall == 0) begin
          held = o_px;
        end else begin
          chk($sformatf("%s stall_px%0d", tag, stall), 64'(o_px), 64'(held));
          chk($sformatf("%s stall_valid%0d", tag, stall), 64'(o_px_valid), 64'd1);
          chk($sformatf("%s stall_reads%0d", tag, stall), 64'(rd_q.size()), 64'd2);
        end
        stall++;
      end else begin
        i_px_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_px_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " finished"}, 64'(done_cnt != 0), 64'd1);
    chk({tag, " nreads"}, 64'(rd_q.size()), 64'(exp_q.size()));
    chk({tag, " npx"}, 64'(px_q.size()), 64'(exp_q.size()));
    lim = (rd_q.size() < exp_q.size()) ? rd_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      chk($sformatf("%s addr%0d", tag, i), 64'(rd_q[i]), 64'(exp_q[i]));
    lim = (px_q.size() < exp_q.size()) ? px_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      chk($sformatf("%s px%0d", tag, i), 64'(px_q[i]), 64'(mem8(exp_q[i])));
      chk($sformatf("%s last%0d", tag, i), 64'(last_q[i]), 64'(i == exp_q.size() - 1));
    end
    chk({tag, " count"}, 64'(o_count), 64'(exp_q.size()));
    chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, " err_pulses"}, 64'(err_cnt), 64'(bad));
    chk({tag, " idle"}, 64'(o_busy), 64'd0);
    if (!bad) chk({tag, " rank"}, 64'(o_rank), 64'(k));
  endtask

  initial begin
    int               cyc;
    logic [MN*MN-1:0] m;
    rst          = 1'b0;
    i_start      = 1'b0;
    i_base_addr  = '0;
    i_parameters = '0;
    i_mask       = '0;
    i_px_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", out_vec(), 64'd0);
    #2 rst = 1'b1;

    run_fetch("n3_full", 32'h100, 8'd3, 8'd7, 16'd16, '1, 0, 1'b0);
    run_fetch("n5_center", 32'h0, 8'd5, 8'd2, 16'd8, 25'h0001000, 0, 1'b0);
    run_fetch("n3_stall", 32'h2000, 8'd3, 8'd1, 16'd32, '1, 2, 1'b0);
    run_fetch("n0_err", 32'h300, 8'd0, 8'd1, 16'd4, '1, 0, 1'b0);
    run_fetch("n6_err", 32'h300, 8'd6, 8'd1, 16'd4, '1, 0, 1'b0);

    m = '1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[MN*MN-1-(r*MN+c)] = 1'b0;
    run_fetch("n3_zero_in_window", 32'h500, 8'd3, 8'd3, 16'd10, m, 0, 1'b0);
    run_fetch("wrap", 32'hFFFF_FFFE, 8'd2, 8'd9, 16'd1, '1, 0, 1'b0);

    clear_log();
    @(posedge clk); #1;
    i_base_addr  = 32'h40;
    i_parameters = {16'd4, 8'hA5, 8'd3};
    i_mask       = '1;
    i_start      = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 0;
    while (!(o_px_valid && px_q.size() == 2) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    i_px_ready = 1'b0;
    chk("rst_reached_third_px", 64'(o_px_valid && px_q.size() == 2), 64'd1);
    chk("rst_pre_count", 64'(o_count), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_outputs", out_vec(), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    i_px_ready = 1'b1;
    run_fetch("post_rst_poke", 32'h40, 8'd3, 8'd5, 16'd4, '1, 0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      run_fetch($sformatf("rnd%0d", t), $urandom, 8'($urandom_range(1, MN)), 8'($urandom),
                16'($urandom), MN*MN'($urandom), 1, t == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
